dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 27, DRAM user-interface address width.
- DATA_WIDTH, 128, DRAM data width.
- MASK_WIDTH, 16, byte write mask width (DATA_WIDTH/8).
- TIMEOUT, 1023, maximum cycles a read may remain outstanding.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, the single clock; all logic on the rising edge.
- reset, in, 1, asynchronous active-high reset.
- pN_ren (N=0,1), in, 1, read request; held until pN_ack.
- pN_wen, in, 1, write request; held until pN_ack.
- pN_addr, in, ADDR_WIDTH, request address.
- pN_wdata, in, DATA_WIDTH, write data.
- pN_wmask, in, MASK_WIDTH, write mask; 1 = byte masked.
- pN_ack, out, 1, 1-cycle pulse when the command is issued to DRAM.
- pN_rdata, out, DATA_WIDTH, read data; valid only with pN_rvalid.
- pN_rvalid, out, 1, 1-cycle pulse when read data returns.
- dram_ren / dram_wen, out, 1, command strobes to the DRAM controller.
- dram_addr, out, ADDR_WIDTH; dram_wdata, out, DATA_WIDTH; dram_wmask, out, MASK_WIDTH.
- dram_busy, in, 1, DRAM controller cannot accept a command this cycle.
- dram_init_calib_complete, in, 1, DRAM calibration done.
- dram_rdata, in, DATA_WIDTH; dram_rvalid, in, 1, read return.
- timeout_err, out, 1, sticky read-timeout flag.

Function
REQ-003 The block SHALL use two states: IDLE and READ_WAIT.
REQ-004 In IDLE, a command SHALL be issued only when dram_init_calib_complete=1, dram_busy=0, and at least one port requests.
REQ-005 Issue SHALL be combinational in the same cycle: dram_ren or dram_wen, dram_addr, dram_wdata and dram_wmask are driven from the winner, and the winner's pN_ack=1.
REQ-006 Arbitration SHALL be round-robin: when both ports request, the port not granted last wins; last_grant updates on every issue.
REQ-007 If a port asserts both ren and wen, the read SHALL be issued and wen ignored for that issue.
REQ-008 A read issue SHALL move the FSM to READ_WAIT next cycle and record the owner; a write issue SHALL stay in IDLE, so back-to-back writes are allowed every cycle.
REQ-009 In READ_WAIT, no command SHALL be issued and all pN_ack SHALL be 0.
REQ-010 In READ_WAIT, when dram_rvalid=1, the owner's pN_rvalid SHALL be 1 in the same cycle, and the FSM SHALL return to IDLE next cycle; the non-owner's rvalid SHALL remain 0.
REQ-011 pN_rdata SHALL equal dram_rdata for both ports at all times (broadcast); qualification is by rvalid only.
REQ-012 dram_rvalid in IDLE SHALL be dropped, with no pN_rvalid asserted.
REQ-013 A counter SHALL be cleared on entry to READ_WAIT and increment each READ_WAIT cycle.
REQ-014 If the counter reaches TIMEOUT without dram_rvalid, the block SHALL set timeout_err (sticky until reset) and return to IDLE; any later return is dropped per REQ-012.
REQ-015 When no command is issued, dram_ren and dram_wen SHALL be 0; dram_addr, dram_wdata and dram_wmask are don't-care.

Reset
REQ-016 Reset SHALL asynchronously force: state=IDLE, last_grant=1 (port 0 wins first), counter=0, timeout_err=0. All pN_ack, pN_rvalid, dram_ren and dram_wen SHALL be 0 while reset is high.
REQ-017 Reset during READ_WAIT SHALL abandon the outstanding read; its later dram_rvalid SHALL be dropped.

Verification
REQ-018 Calibration gate: dram_init_calib_complete=0, p0_ren=1 for 20 cycles -> no dram_ren and no p0_ack. Raise calib -> dram_ren and p0_ack in the same cycle.
REQ-019 Contention: p0_wen and p1_wen held continuously after reset -> acks alternate p0, p1, p0, p1 on consecutive cycles, with dram_addr matching each winner.
REQ-020 Read ownership: p1_ren at addr 0x0000100, dram_rvalid 7 cycles later with rdata 0xA5..A5 -> p1_rvalid=1 with that data, p0_rvalid=0, and no issue during the 7 wait cycles even with p0_wen held.
REQ-021 Backpressure: dram_busy=1 for 5 cycles with p0_wen held -> no ack. dram_busy drops -> p0_ack in that cycle.
REQ-022 Timeout: read issued, no dram_rvalid for TIMEOUT cycles -> timeout_err=1 and FSM in IDLE. A late dram_rvalid -> no pN_rvalid. A subsequent p0_ren is accepted.
REQ-023 Reset mid-read: assert reset in READ_WAIT, release, then dram_rvalid -> no pN_rvalid, and the first grant goes to port 0.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of a DRAM user interface.
// One read may be outstanding at a time; writes can issue back-to-back.
module dram_arbiter #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p0_ren,
    input  logic                  p0_wen,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [MASK_WIDTH-1:0] p0_wmask,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_rvalid,
    input  logic                  p1_ren,
    input  logic                  p1_wen,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [MASK_WIDTH-1:0] p1_wmask,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_rvalid,
    output logic                  dram_ren,
    output logic                  dram_wen,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [DATA_WIDTH-1:0] dram_wdata,
    output logic [MASK_WIDTH-1:0] dram_wmask,
    input  logic                  dram_busy,
    input  logic                  dram_init_calib_complete,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    input  logic                  dram_rvalid,
    output logic                  timeout_err
);

    // state     | meaning
    // IDLE      | may issue a command to the winning port
    // READ_WAIT | one read outstanding, waiting for dram_rvalid or timeout
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] READ_WAIT = 1'b1;

    localparam int CNT_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    logic [0:0]           state_q, state_d;
    logic                 last_q, last_d;
    logic                 owner_q, owner_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic req0, req1, issue, win1, sel_ren, sel_wen, rsp;

    assign p0_rdata    = dram_rdata;
    assign p1_rdata    = dram_rdata;
    assign timeout_err = err_q;

    always_comb begin
        req0    = p0_ren | p0_wen;
        req1    = p1_ren | p1_wen;
        issue   = !reset && (state_q == IDLE) && dram_init_calib_complete &&
                  !dram_busy && (req0 || req1);
        // last_q holds the index of the previously granted port
        win1    = req1 && (!req0 || !last_q);
        sel_ren = win1 ? p1_ren : p0_ren;
        sel_wen = win1 ? p1_wen : p0_wen;

        dram_ren   = issue && sel_ren;
        dram_wen   = issue && !sel_ren && sel_wen;
        dram_addr  = win1 ? p1_addr  : p0_addr;
        dram_wdata = win1 ? p1_wdata : p0_wdata;
        dram_wmask = win1 ? p1_wmask : p0_wmask;
        p0_ack     = issue && !win1;
        p1_ack     = issue && win1;

        rsp       = !reset && (state_q == READ_WAIT) && dram_rvalid;
        p0_rvalid = rsp && !owner_q;
        p1_rvalid = rsp && owner_q;

        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    last_d = win1;
                    if (sel_ren) begin
                        state_d = READ_WAIT;
                        owner_d = win1;
                        cnt_d   = '0;
                    end
                end
            end
            READ_WAIT: begin
                if (dram_rvalid) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_dram_arbiter;

    localparam int AW  = 27;
    localparam int DW  = 128;
    localparam int MW  = 16;
    localparam int TMO = 50;

    logic clock = 1'b0;
    logic reset;
    logic p0_ren, p0_wen, p1_ren, p1_wen;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic [MW-1:0] p0_wmask, p1_wmask;
    logic p0_ack, p1_ack, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic dram_ren, dram_wen;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wdata;
    logic [MW-1:0] dram_wmask;
    logic dram_busy, dram_init_calib_complete, dram_rvalid;
    logic [DW-1:0] dram_rdata;
    logic timeout_err;

    always #5 clock = ~clock;

    dram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .p0_ren(p0_ren), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wmask(p0_wmask), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_ren(p1_ren), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wmask(p1_wmask), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_wmask(dram_wmask), .dram_busy(dram_busy),
        .dram_init_calib_complete(dram_init_calib_complete),
        .dram_rdata(dram_rdata), .dram_rvalid(dram_rvalid), .timeout_err(timeout_err)
    );

    typedef struct {
        int            cyc;
        logic          ren, wen, a0, a1, v0, v1, err;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // transaction-level reference state
    bit m_pend  = 0;
    bit m_owner = 0;
    int m_age   = 0;
    bit m_last  = 1;
    bit m_err   = 0;
    bit g0, g1;

    task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cycle, got, exp);
        end
    endtask

    // Evaluate the model on the inputs currently applied, queue any expected event, advance.
    task automatic cyc();
        exp_t e;
        bit   ev = 0;
        bit   r0, r1, w, wr_r;
        e = '{default: '0};
        e.cyc = cycle;
        g0 = 0;
        g1 = 0;
        r0 = p0_ren | p0_wen;
        r1 = p1_ren | p1_wen;
        if (reset) begin
            m_pend = 0; m_last = 1; m_err = 0; m_age = 0;
        end else begin
            e.err = m_err;
            if (m_pend) begin
                if (dram_rvalid) begin
                    ev = 1;
                    if (m_owner) e.v1 = 1; else e.v0 = 1;
                    e.rdata = dram_rdata;
                    m_pend = 0;
                end else begin
                    m_age++;
                    if (m_age == TMO) begin
                        m_pend = 0;
                        m_err  = 1;
                    end
                end
            end else if (dram_init_calib_complete && !dram_busy && (r0 || r1)) begin
                w = (r0 && r1) ? !m_last : r1;
                ev = 1;
                e.a0 = !w;
                e.a1 = w;
                wr_r = w ? p1_ren : p0_ren;
                e.addr = w ? p1_addr : p0_addr;
                if (wr_r) begin
                    e.ren = 1;
                    m_pend = 1; m_owner = w; m_age = 0;
                end else begin
                    e.wen   = 1;
                    e.wdata = w ? p1_wdata : p0_wdata;
                    e.wmask = w ? p1_wmask : p0_wmask;
                end
                m_last = w;
                g0 = !w;
                g1 = w;
            end
        end
        if (ev) q.push_back(e);
        @(negedge clock);
        cycle++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // monitor: compares whenever the DUT presents an event
    initial begin
        exp_t e;
        logic dut_ev;
        forever begin
            @(negedge clock);
            #2;
            check("p0_rdata_bcast", p0_rdata, dram_rdata);
            check("p1_rdata_bcast", p1_rdata, dram_rdata);
            while (q.size() > 0 && q[0].cyc < cycle) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event cycle %0d: got no event, expected ren=%0b wen=%0b ack=%0b%0b rvalid=%0b%0b",
                         e.cyc, e.ren, e.wen, e.a1, e.a0, e.v1, e.v0);
            end
            dut_ev = dram_ren | dram_wen | p0_ack | p1_ack | p0_rvalid | p1_rvalid;
            if (dut_ev) begin
                if (q.size() > 0 && q[0].cyc == cycle) begin
                    e = q.pop_front();
                    check("ctrl{ren,wen,ack1,ack0,rv1,rv0,err}",
                          DW'({dram_ren, dram_wen, p1_ack, p0_ack, p1_rvalid, p0_rvalid, timeout_err}),
                          DW'({e.ren, e.wen, e.a1, e.a0, e.v1, e.v0, e.err}));
                    if (e.ren || e.wen) check("dram_addr", DW'(dram_addr), DW'(e.addr));
                    if (e.wen) begin
                        check("dram_wdata", dram_wdata, e.wdata);
                        check("dram_wmask", DW'(dram_wmask), DW'(e.wmask));
                    end
                    if (e.v0) check("p0_rdata", p0_rdata, e.rdata);
                    if (e.v1) check("p1_rdata", p1_rdata, e.rdata);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event cycle %0d: got ren=%0b wen=%0b ack=%0b%0b rvalid=%0b%0b, expected no event",
                             cycle, dram_ren, dram_wen, p1_ack, p0_ack, p1_rvalid, p0_rvalid);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; dram_init_calib_complete = 0; dram_busy = 0; dram_rvalid = 0;
        dram_rdata = '0;
        p0_ren = 0; p0_wen = 0; p1_ren = 0; p1_wen = 0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0; p0_wmask = '0; p1_wmask = '0;
        @(negedge clock);

        // reset: calib up and requests present, still no activity allowed
        dram_init_calib_complete = 1;
        p0_wen = 1; p1_ren = 1; dram_rvalid = 1;
        cycles(3);
        check("reset_timeout_err", DW'(timeout_err), DW'(0));
        p0_wen = 0; p1_ren = 0; dram_rvalid = 0; dram_init_calib_complete = 0;
        reset = 0;
        cyc();

        // calibration gate
        p0_ren = 1; p0_addr = 27'h0123456;
        cycles(20);
        dram_init_calib_complete = 1;
        cyc();
        p0_ren = 0;
        dram_rdata = {4{32'h1234_5678}}; dram_rvalid = 1;
        cyc();
        dram_rvalid = 0;

        // contention right after reset: port 0 first, then alternate
        reset = 1; cyc(); reset = 0;
        p0_wen = 1; p0_addr = 27'h0000AAA; p0_wdata = {4{32'hCAFE_0000}}; p0_wmask = 16'h00F0;
        p1_wen = 1; p1_addr = 27'h0000BBB; p1_wdata = {4{32'hBEEF_1111}}; p1_wmask = 16'h0F00;
        cycles(6);
        p0_wen = 0; p1_wen = 0;

        // read ownership with port 0 writes held during the wait
        p1_ren = 1; p1_addr = 27'h0000100;
        cyc();
        p1_ren = 0; p0_wen = 1;
        cycles(6);
        dram_rvalid = 1; dram_rdata = {16{8'hA5}};
        cyc();
        dram_rvalid = 0;
        cyc();
        p0_wen = 0;

        // backpressure
        dram_busy = 1; p0_wen = 1; p0_addr = 27'h0000777;
        cycles(5);
        dram_busy = 0;
        cyc();
        p0_wen = 0;

        // timeout, late return dropped, next read accepted
        p0_ren = 1; p0_addr = 27'h0000200;
        cyc();
        p0_ren = 0;
        cycles(TMO);
        check("timeout_err_set", DW'(timeout_err), DW'(1));
        dram_rvalid = 1; dram_rdata = {4{32'hDEAD_BEEF}};
        cyc();
        dram_rvalid = 0;
        p0_ren = 1; p0_addr = 27'h0000300;
        cyc();
        p0_ren = 0;
        dram_rvalid = 1;
        cyc();
        dram_rvalid = 0;
        check("timeout_err_sticky", DW'(timeout_err), DW'(1));

        // reset mid-read
        p1_ren = 1; p1_addr = 27'h0000400;
        cyc();
        p1_ren = 0;
        cycles(2);
        reset = 1; cyc(); reset = 0;
        check("timeout_err_cleared", DW'(timeout_err), DW'(0));
        dram_rvalid = 1;
        cyc();
        dram_rvalid = 0;
        p0_wen = 1; p1_wen = 1;
        cyc();
        p0_wen = 0; p1_wen = 0;
        cyc();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            if (!p0_ren && !p0_wen && ($urandom_range(0, 2) == 0)) begin
                int k = $urandom_range(0, 4);
                p0_ren = (k < 2) || (k == 4);
                p0_wen = (k >= 2);
                p0_addr = AW'($urandom);
                p0_wdata = {$urandom, $urandom, $urandom, $urandom};
                p0_wmask = MW'($urandom);
            end
            if (!p1_ren && !p1_wen && ($urandom_range(0, 2) == 0)) begin
                int k = $urandom_range(0, 4);
                p1_ren = (k < 2) || (k == 4);
                p1_wen = (k >= 2);
                p1_addr = AW'($urandom);
                p1_wdata = {$urandom, $urandom, $urandom, $urandom};
                p1_wmask = MW'($urandom);
            end
            dram_busy = ($urandom_range(0, 3) == 0);
            dram_init_calib_complete = ($urandom_range(0, 15) != 0);
            dram_rdata = {$urandom, $urandom, $urandom, $urandom};
            dram_rvalid = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            cyc();
            if (g0) begin p0_ren = 0; p0_wen = 0; end
            if (g1) begin p1_ren = 0; p1_wen = 0; end
        end
        reset = 0; dram_rvalid = 0;
        p0_ren = 0; p0_wen = 0; p1_ren = 0; p1_wen = 0;
        cycles(2);
        #3;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event cycle %0d: got no event, expected ack=%0b%0b rvalid=%0b%0b",
                     e.cyc, e.a1, e.a0, e.v1, e.v0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
